// File: rtl/reduce_pkg.sv
// Shared types and width helper for the array reduction engine.
package reduce_pkg;

    typedef enum logic [1:0] {
        MODE_MAC = 2'b00,
        MODE_SB0 = 2'b01,
        MODE_SB1 = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // Wide enough for a full tile row over every array, accumulated over the longest group.
    function automatic int sum_w(input int acc_width, input int num_arrays,
                                 input int tile_size, input int len_w);
        return acc_width + $clog2(num_arrays * tile_size) + len_w;
    endfunction

endpackage

// File: rtl/row_sum_tree.sv
// Combinational masked adder tree: per-row sum across the selected arrays.
module row_sum_tree
    import reduce_pkg::*;
#(
    parameter int NUM_ARRAYS = 4,
    parameter int TILE_SIZE  = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int LEN_W      = 8,
    localparam int SUM_W     = sum_w(ACC_WIDTH, NUM_ARRAYS, TILE_SIZE, LEN_W)
) (
    input  logic [NUM_ARRAYS-1:0]                                          mask,
    input  logic signed [NUM_ARRAYS-1:0][TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] in_mat,
    output logic signed [TILE_SIZE-1:0][SUM_W-1:0]                         rs
);

    logic signed [SUM_W-1:0] lane_sum_s;

    // Sign-extend every element before adding so no partial sum can overflow.
    always_comb begin
        rs         = '0;
        lane_sum_s = '0;
        for (int i = 0; i < TILE_SIZE; i++) begin
            lane_sum_s = '0;
            for (int a = 0; a < NUM_ARRAYS; a++) begin
                for (int j = 0; j < TILE_SIZE; j++) begin
                    if (mask[a]) begin
                        lane_sum_s = lane_sum_s + SUM_W'($signed(in_mat[a][i][j]));
                    end else begin
                        lane_sum_s = lane_sum_s;
                    end
                end
            end
            rs[i] = lane_sum_s;
        end
    end

endmodule

// File: rtl/array_reduction_engine.sv
// Row-sum reduction with optional temporal (MAC) accumulation and a registered output stage.
// Optional macro REDUCE_SAT_EN: saturating output narrowing plus a sat_flag output.
module array_reduction_engine
    import reduce_pkg::*;
#(
    parameter int NUM_ARRAYS = 4,
    parameter int TILE_SIZE  = 4,
    parameter int ACC_WIDTH  = 32,
    parameter int LEN_W      = 8
) (
    input  logic                                                           clk,
    input  logic                                                           rst_n,
    input  logic [1:0]                                                     mode,
    input  logic [LEN_W-1:0]                                               cfg_acc_len,
    input  logic [NUM_ARRAYS-1:0]                                          cfg_array_mask,
    input  logic                                                           in_valid,
    output logic                                                           in_ready,
    input  logic signed [NUM_ARRAYS-1:0][TILE_SIZE-1:0][TILE_SIZE-1:0][ACC_WIDTH-1:0] in_mat,
    output logic                                                           out_valid,
    input  logic                                                           out_ready,
    output logic signed [TILE_SIZE-1:0][ACC_WIDTH-1:0]                     out_vec,
    output logic                                                           busy,
`ifdef REDUCE_SAT_EN
    output logic                                                           sat_flag,
`endif
    output logic                                                           cfg_err
);

    localparam int SUM_W = sum_w(ACC_WIDTH, NUM_ARRAYS, TILE_SIZE, LEN_W);

`ifdef REDUCE_SAT_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

    function automatic logic sat_hit(input logic signed [SUM_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction
`endif

    function automatic logic [ACC_WIDTH-1:0] narrow(input logic signed [SUM_W-1:0] v);
`ifdef REDUCE_SAT_EN
        if (v > SAT_MAX) begin
            return SAT_MAX[ACC_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[ACC_WIDTH-1:0];
        end else begin
            return v[ACC_WIDTH-1:0];
        end
`else
        return v[ACC_WIDTH-1:0];
`endif
    endfunction

    state_e                                   state_r;
    logic [LEN_W-1:0]                         cnt_r;
    logic [LEN_W-1:0]                         len_r;
    logic [NUM_ARRAYS-1:0]                    mask_r;
    logic signed [TILE_SIZE-1:0][SUM_W-1:0]   acc_r;
    logic                                     out_valid_r;
    logic signed [TILE_SIZE-1:0][ACC_WIDTH-1:0] out_vec_r;
    logic                                     cfg_err_r;
`ifdef REDUCE_SAT_EN
    logic                                     sat_r;
    logic                                     next_sat_s;
`endif

    logic                                     accept_s;
    logic [NUM_ARRAYS-1:0]                    mask_s;
    logic [LEN_W-1:0]                         eff_len_s;
    logic signed [TILE_SIZE-1:0][SUM_W-1:0]   rs_s;
    logic signed [TILE_SIZE-1:0][SUM_W-1:0]   full_sum_s;
    logic signed [TILE_SIZE-1:0][ACC_WIDTH-1:0] next_vec_s;

    assign in_ready  = !out_valid_r || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign eff_len_s = (cfg_acc_len == '0) ? LEN_W'(1) : cfg_acc_len;
    // The first beat of a group uses the live mask; later beats use the latched one.
    assign mask_s    = (state_r == ST_IDLE) ? cfg_array_mask : mask_r;

    row_sum_tree #(
        .NUM_ARRAYS (NUM_ARRAYS),
        .TILE_SIZE  (TILE_SIZE),
        .ACC_WIDTH  (ACC_WIDTH),
        .LEN_W      (LEN_W)
    ) u_row_sum_tree (
        .mask   (mask_s),
        .in_mat (in_mat),
        .rs     (rs_s)
    );

    // Candidate result for this beat: running sum plus new row sums while accumulating.
    always_comb begin
        full_sum_s = '0;
        next_vec_s = '0;
`ifdef REDUCE_SAT_EN
        next_sat_s = 1'b0;
`endif
        for (int i = 0; i < TILE_SIZE; i++) begin
            if (state_r == ST_ACCUM) begin
                full_sum_s[i] = acc_r[i] + rs_s[i];
            end else begin
                full_sum_s[i] = rs_s[i];
            end
            next_vec_s[i] = narrow(full_sum_s[i]);
`ifdef REDUCE_SAT_EN
            next_sat_s = next_sat_s | sat_hit(full_sum_s[i]);
`endif
        end
    end

    // Group FSM, accumulator, config latch and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            len_r       <= LEN_W'(1);
            mask_r      <= '0;
            acc_r       <= '0;
            out_valid_r <= 1'b0;
            out_vec_r   <= '0;
            cfg_err_r   <= 1'b0;
`ifdef REDUCE_SAT_EN
            sat_r       <= 1'b0;
`endif
        end else begin
            if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
            if (accept_s) begin
                case (state_r)
                    ST_IDLE: begin
                        mask_r <= cfg_array_mask;
                        len_r  <= eff_len_s;
                        if (mode == MODE_RSV) begin
                            cfg_err_r <= 1'b1;
                        end
                        if ((mode == MODE_MAC) && (eff_len_s > LEN_W'(1))) begin
                            state_r <= ST_ACCUM;
                            acc_r   <= rs_s;
                            cnt_r   <= LEN_W'(1);
                        end else begin
                            out_valid_r <= 1'b1;
                            out_vec_r   <= next_vec_s;
`ifdef REDUCE_SAT_EN
                            sat_r       <= next_sat_s;
`endif
                        end
                    end
                    ST_ACCUM: begin
                        if (cnt_r == (len_r - LEN_W'(1))) begin
                            state_r     <= ST_IDLE;
                            cnt_r       <= '0;
                            out_valid_r <= 1'b1;
                            out_vec_r   <= next_vec_s;
`ifdef REDUCE_SAT_EN
                            sat_r       <= next_sat_s;
`endif
                        end else begin
                            acc_r <= full_sum_s;
                            cnt_r <= cnt_r + LEN_W'(1);
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                    end
                endcase
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_vec   = out_vec_r;
    assign busy      = (state_r == ST_ACCUM);
    assign cfg_err   = cfg_err_r;
`ifdef REDUCE_SAT_EN
    assign sat_flag  = sat_r;
`endif

endmodule

// File: tb/tb_array_reduction_engine.sv
// Scoreboard bench for array_reduction_engine (NUM_ARRAYS=4, TILE_SIZE=4, ACC_WIDTH=32).
module tb_array_reduction_engine;

    typedef logic [3:0][3:0][3:0][31:0] mat_t;
    typedef logic [3:0][31:0]           vec_t;
    typedef struct packed {
        vec_t vec;
        logic sat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  cfg_acc_len = 8'd0;
    logic [3:0]  cfg_array_mask = 4'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    mat_t        in_mat = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    vec_t        out_vec;
    logic        busy;
    logic        cfg_err;
`ifdef REDUCE_SAT_EN
    logic        sat_flag;
`endif

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    array_reduction_engine #(
        .NUM_ARRAYS (4),
        .TILE_SIZE  (4),
        .ACC_WIDTH  (32),
        .LEN_W      (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mode           (mode),
        .cfg_acc_len    (cfg_acc_len),
        .cfg_array_mask (cfg_array_mask),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mat         (in_mat),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_vec        (out_vec),
        .busy           (busy),
`ifdef REDUCE_SAT_EN
        .sat_flag       (sat_flag),
`endif
        .cfg_err        (cfg_err)
    );

    always #5 clk = ~clk;

    function automatic mat_t fill(input logic [31:0] v0, input logic [31:0] v1,
                                  input logic [31:0] v2, input logic [31:0] v3);
        mat_t m;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                m[0][i][j] = v0;
                m[1][i][j] = v1;
                m[2][i][j] = v2;
                m[3][i][j] = v3;
            end
        end
        return m;
    endfunction

    function automatic vec_t splat(input logic [31:0] v);
        vec_t r;
        for (int i = 0; i < 4; i++) r[i] = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic expect_out(input logic [31:0] lane, input logic sat);
        exp_t e;
        e.vec = splat(lane);
        e.sat = sat;
        sb_q.push_back(e);
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [1:0] m, input logic [7:0] l, input logic [3:0] k, input mat_t mat);
        int t;
        mode = m;
        cfg_acc_len = l;
        cfg_array_mask = k;
        in_mat = mat;
        in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 100) begin
                n_vec++;
                n_bad++;
                $display("FAIL accept_timeout: in_ready stuck at %b, expected 1", in_ready);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every output handshake is popped and compared against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_out: got %h, expected no output", out_vec);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (out_vec !== e.vec) begin
                    n_bad++;
                    $display("FAIL out_vec: got %h, expected %h", out_vec, e.vec);
                end
`ifdef REDUCE_SAT_EN
                n_vec++;
                if (sat_flag !== e.sat) begin
                    n_bad++;
                    $display("FAIL sat_flag: got %b, expected %b", sat_flag, e.sat);
                end
`endif
            end
        end
    end

    initial begin
        int t;
        // Reset state
        #2;
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_out_vec",   128'(out_vec),   128'(0));
        check("rst_busy",      128'(busy),      128'(1'b0));
        check("rst_cfg_err",   128'(cfg_err),   128'(1'b0));
        check("rst_in_ready",  128'(in_ready),  128'(1'b1));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single beat, mask selects array 0 only
        expect_out(32'd4, 1'b0);
        send(2'b01, 8'd1, 4'b0001, fill(32'd1, 32'd5, 32'd5, 32'd5));
        @(negedge clk);
        check("sb_valid_rise", 128'(out_valid), 128'(1'b1));
        @(negedge clk);
        check("sb_valid_pulse", 128'(out_valid), 128'(1'b0));
        @(posedge clk); #1;

        // MAC over 3 beats
        send(2'b00, 8'd3, 4'b1111, fill(32'd2, 32'd2, 32'd2, 32'd2));
        @(negedge clk);
        check("mac_b1_busy",  128'(busy),      128'(1'b1));
        check("mac_b1_valid", 128'(out_valid), 128'(1'b0));
        @(posedge clk); #1;
        send(2'b00, 8'd3, 4'b1111, fill(32'd2, 32'd2, 32'd2, 32'd2));
        @(negedge clk);
        check("mac_b2_busy",  128'(busy),      128'(1'b1));
        check("mac_b2_valid", 128'(out_valid), 128'(1'b0));
        @(posedge clk); #1;
        expect_out(32'd96, 1'b0);
        send(2'b00, 8'd3, 4'b1111, fill(32'd2, 32'd2, 32'd2, 32'd2));
        @(negedge clk);
        check("mac_b3_valid", 128'(out_valid), 128'(1'b1));
        check("mac_b3_busy",  128'(busy),      128'(1'b0));
        @(posedge clk); #1;

        // Backpressure, then release together with a new completing beat
        out_ready = 1'b0;
        expect_out(32'd16, 1'b0);
        send(2'b01, 8'd1, 4'b1111, fill(32'd1, 32'd1, 32'd1, 32'd1));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_vec_stable", 128'(out_vec),  128'(splat(32'd16)));
            check("bp_in_ready",   128'(in_ready), 128'(1'b0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        expect_out(32'd12, 1'b0);
        send(2'b01, 8'd1, 4'b0010, fill(32'd9, 32'd3, 32'd9, 32'd9));
        @(negedge clk);
        check("bp_valid_held", 128'(out_valid), 128'(1'b1));
        check("bp_new_vec",    128'(out_vec),   128'(splat(32'd12)));
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset mid-group discards the partial accumulation
        send(2'b00, 8'd3, 4'b1111, fill(32'd2, 32'd2, 32'd2, 32'd2));
        send(2'b00, 8'd3, 4'b1111, fill(32'd2, 32'd2, 32'd2, 32'd2));
        rst_n = 1'b0;
        #2;
        check("mid_rst_valid", 128'(out_valid), 128'(1'b0));
        check("mid_rst_vec",   128'(out_vec),   128'(0));
        check("mid_rst_busy",  128'(busy),      128'(1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        // Later beats change the live mask; the latched mask must win
        send(2'b00, 8'd3, 4'b0001, fill(32'd1, 32'd7, 32'd7, 32'd7));
        send(2'b00, 8'd3, 4'b1111, fill(32'd1, 32'd7, 32'd7, 32'd7));
        expect_out(32'd12, 1'b0);
        send(2'b00, 8'd3, 4'b1111, fill(32'd1, 32'd7, 32'd7, 32'd7));
        @(negedge clk);
        check("post_rst_valid", 128'(out_valid), 128'(1'b1));
        @(posedge clk); #1;

        // Overflow on narrowing
`ifdef REDUCE_SAT_EN
        expect_out(32'h7FFF_FFFF, 1'b1);
`else
        expect_out(32'hFFFF_FFF0, 1'b0);
`endif
        send(2'b01, 8'd1, 4'b1111, fill(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF));
        @(posedge clk); #1;

        // Reserved mode acts as single beat and sets sticky cfg_err
        expect_out(32'd4, 1'b0);
        send(2'b11, 8'd5, 4'b0001, fill(32'd1, 32'd0, 32'd0, 32'd0));
        @(negedge clk);
        check("rsv_valid",   128'(out_valid), 128'(1'b1));
        check("rsv_cfg_err", 128'(cfg_err),   128'(1'b1));
        check("rsv_busy",    128'(busy),      128'(1'b0));
        @(posedge clk); #1;

        // MAC with len 0 behaves as a single beat
        expect_out(32'hFFFF_FFFC, 1'b0);
        send(2'b00, 8'd0, 4'b0100, fill(32'd3, 32'd3, 32'hFFFF_FFFF, 32'd3));
        @(negedge clk);
        check("len0_valid",   128'(out_valid), 128'(1'b1));
        check("len0_busy",    128'(busy),      128'(1'b0));
        check("len0_cfg_err", 128'(cfg_err),   128'(1'b1));

        // Drain
        t = 0;
        while (sb_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("sb_drained", 128'(sb_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/array_reduction_engine.md
Name: array_reduction_engine

Overview:
- Parametrised successor to the fixed 4-array reduction path.
- Accepts NUM_ARRAYS tile results (TILE_SIZE x TILE_SIZE) per beat and forms per-row sums across a runtime-selected subset of arrays.
- In MAC mode, accumulates those row sums over a runtime-configured number of beats; in single-beat modes, emits them directly.
- Sits between the systolic array cluster and the write-back/requant stage; valid/ready on both sides.

Parameters:
- NUM_ARRAYS, 4, number of array result matrices per beat
- TILE_SIZE, 4, tile edge length
- ACC_WIDTH, 32, signed width of input elements and output vector elements
- LEN_W, 8, width of cfg_acc_len

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  00 MAC (temporal accumulate), 01/10 single-beat, 11 reserved
- cfg_acc_len  in  LEN_W  beats per MAC group; 0 is treated as 1
- cfg_array_mask  in  NUM_ARRAYS  bit a=1 includes array a in the sum
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_mat  in  NUM_ARRAYS x TILE_SIZE x TILE_SIZE x ACC_WIDTH signed  array results
- out_valid  out  1  result vector valid
- out_ready  in  1  downstream accepts result
- out_vec  out  TILE_SIZE x ACC_WIDTH signed  reduced vector
- busy  out  1  high while a MAC group is partially accumulated
- cfg_err  out  1  sticky; set when a group starts with mode 11

Behaviour:
- Internal sum width: SUM_W = ACC_WIDTH + clog2(NUM_ARRAYS*TILE_SIZE) + LEN_W, signed. No internal overflow is possible.
- Row sum per accepted beat: rs[i] = sum over masked a, sum over j of in_mat[a][i][j], sign-extended to SUM_W. Mask 0 gives all-zero rs.
- Config latch: mode, cfg_acc_len and cfg_array_mask are sampled on the first beat of each group. Later changes take effect at the next group only.
- FSM states:
  - IDLE: on accept, mode 00 with len>1 -> ACCUM (acc=rs, cnt=1); otherwise load the output register from rs and stay in IDLE.
  - ACCUM: on accept, acc+=rs, cnt++. When cnt reaches len, load the output register from acc+rs, clear cnt, go to IDLE.
- Mode 11 is handled as single-beat and sets cfg_err; only reset clears cfg_err.
- Handshake: in_ready = !out_valid || out_ready, combinational.
  - An accepted beat that does not complete a group never depends on the output register.
  - A completing beat may be accepted in the same cycle the previous result is taken.
- Output register:
  - out_valid rises the cycle after the completing beat is accepted.
  - Latency is 1 cycle for single-beat, and 1 cycle after the L-th beat for MAC.
  - out_vec and out_valid hold stable while out_valid && !out_ready.
  - out_valid drops after the handshake unless a new completing beat loads in the same cycle, in which case it stays high with the new data.
- Output narrowing: SUM_W -> ACC_WIDTH by truncation (wrap), keeping the low bits.
- busy = (state == ACCUM).
- Reset (asynchronous, any state including mid-group):
  - out_valid=0, out_vec=0, busy=0, cfg_err=0, cnt=0, acc=0, state IDLE.
  - in_ready is 1 after reset.
  - A partial group is discarded.
- in_valid with in_ready=0: the beat is not consumed; the upstream holds it.

Optional Feature:
- Macro REDUCE_SAT_EN.
- Defined:
  - Output narrowing saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] instead of wrapping.
  - Adds output port sat_flag (1 bit), registered with out_vec. It is high if any lane of the current result saturated, and resets to 0.
- Undefined: truncation only; sat_flag port is absent.

Decomposition:
- Package reduce_pkg: mode enum (MODE_MAC=00, MODE_SB0=01, MODE_SB1=10, MODE_RSV=11), FSM state enum, function sum_w(ACC_WIDTH, NUM_ARRAYS, TILE_SIZE, LEN_W).
- Sub-module row_sum_tree: combinational masked adder tree producing rs[TILE_SIZE] at SUM_W, parametrised identically.
- FSM, counter, accumulator and output register live in array_reduction_engine.

Test Plan (NUM_ARRAYS=4, TILE_SIZE=4, ACC_WIDTH=32):
- Single beat: mode 01, mask 0001, in_mat[0] all 1, others all 5 -> out_vec = {4,4,4,4} one cycle after accept; out_valid pulses one cycle with out_ready=1.
- MAC: mode 00, len 3, mask 1111, all elements 2 -> no out_valid after beats 1-2, busy=1; out_vec = {96,96,96,96} one cycle after beat 3; busy=0.
- Backpressure: result pending, out_ready=0 for 5 cycles -> out_vec stable, in_ready=0. Then out_ready=1 together with a new completing beat -> out_valid stays 1 and the new data appears next cycle.
- Reset mid-group: mode 00, len 3, rst_n low after 2 beats -> all outputs 0. The next 3 beats of value 1 (mask 0001) -> out_vec = {12,12,12,12}, with no residue from the discarded group.
- Overflow: mode 01, mask 1111, all elements 0x7FFFFFFF -> without REDUCE_SAT_EN out_vec lanes = 0xFFFFFFF0 (-16); with it, lanes = 0x7FFFFFFF and sat_flag=1.
- Reserved mode and len 0: mode 11 with one beat -> single-beat result and cfg_err=1, which persists across later groups. Mode 00 with len 0 -> behaves as a single beat.
